bsg_two_fifo_rv: RTL and testbench

// - Two-entry ready/valid FIFO that sits directly upstream of the enable-gated, reset-to-zero state register (bsg_dff_reset_en).
// - Accepts words from a producer and presents them to the consumer. The consumer's yumi_i becomes the downstream register's en_i, and data_o becomes its data_i.
// - Decouples producer back-pressure from consumer timing.
// - Sustains one enqueue plus one dequeue per cycle (full throughput).
//

---
 rtl/bsg_two_fifo_rv.sv | 106 ++++++++++
 tb/tb_bsg_two_fifo_rv.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_two_fifo_rv.sv
// bsg_two_fifo_rv: two-entry ready/valid FIFO feeding an enable-gated state register.
// The head word is presented straight from storage (no bypass), so a word
// enqueued in one cycle appears on v_o/data_o in the next.
// Optional build macro BSG_TWO_FIFO_RV_COUNT_EN adds a registered occupancy
// output count_o (0..2).
module bsg_two_fifo_rv #(
   parameter int width_p                 = 3,
   parameter bit allow_enq_deq_on_full_p = 1'b0
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
   ,
   output logic [1:0]         count_o
`endif
);

   logic [width_p-1:0] mem_r [2];
   logic               rd_ptr_r;
   logic               wr_ptr_r;
   logic               empty_r;
   logic               full_r;

   logic               w_enq;
   logic               w_deq;
   logic               w_ready;

   // Accept a word when not full; optionally also when full and the head leaves this cycle.
   generate
      if (allow_enq_deq_on_full_p) begin : g_ready_full_deq
         assign w_ready = (~full_r | yumi_i) & ~reset_i;
      end else begin : g_ready_plain
         assign w_ready = ~full_r & ~reset_i;
      end
   endgenerate

   assign ready_o = w_ready;
   assign w_enq   = v_i & w_ready;
   // A yumi while empty is a protocol violation; masking it keeps the pointers intact.
   assign w_deq   = yumi_i & ~empty_r;

   assign v_o    = ~empty_r;
   assign data_o = mem_r[rd_ptr_r];

   // Per-entry storage: cleared on reset, written only when enqueued into that slot.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               mem_r[gi] <= '0;
            end else if (w_enq && (wr_ptr_r == 1'(gi))) begin
               mem_r[gi] <= data_i;
            end
         end
      end
   endgenerate

   // Pointer and occupancy-flag update; simultaneous enq and deq leave the flags as they are.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_ptr_r <= 1'b0;
         wr_ptr_r <= 1'b0;
         empty_r  <= 1'b1;
         full_r   <= 1'b0;
      end else begin
         if (w_enq) begin
            wr_ptr_r <= ~wr_ptr_r;
         end
         if (w_deq) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         if (w_enq && !w_deq) begin
            empty_r <= 1'b0;
            full_r  <= ((wr_ptr_r + 1'b1) == rd_ptr_r);
         end
         if (w_deq && !w_enq) begin
            full_r  <= 1'b0;
            empty_r <= ((rd_ptr_r + 1'b1) == wr_ptr_r);
         end
      end
   end

`ifdef BSG_TWO_FIFO_RV_COUNT_EN
   logic [1:0] count_r;

   // Occupancy counter mirroring the empty/full flags.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_r <= 2'd0;
      end else if (w_enq && !w_deq) begin
         count_r <= count_r + 2'd1;
      end else if (w_deq && !w_enq) begin
         count_r <= count_r - 2'd1;
      end
   end

   assign count_o = count_r;
`endif

endmodule

// File: tb/tb_bsg_two_fifo_rv.sv
// Directed testbench for bsg_two_fifo_rv: two instances (full enq&deq disallowed
// and allowed) share stimulus; each scenario task checks outputs inline.
`timescale 1ns/1ps
module tb_bsg_two_fifo_rv;

   logic       clk = 1'b0;
   logic       reset;
   logic       v_in;
   logic [2:0] data_in;
   logic       yumi;

   logic       ready0, v0, ready1, v1;
   logic [2:0] data0, data1;
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
   logic [1:0] count0, count1;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   bsg_two_fifo_rv #(.width_p(3), .allow_enq_deq_on_full_p(1'b0)) dut0 (
      .clk_i   (clk),
      .reset_i (reset),
      .v_i     (v_in),
      .data_i  (data_in),
      .ready_o (ready0),
      .v_o     (v0),
      .data_o  (data0),
      .yumi_i  (yumi)
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
      ,
      .count_o (count0)
`endif
   );

   bsg_two_fifo_rv #(.width_p(3), .allow_enq_deq_on_full_p(1'b1)) dut1 (
      .clk_i   (clk),
      .reset_i (reset),
      .v_i     (v_in),
      .data_i  (data_in),
      .ready_o (ready1),
      .v_o     (v1),
      .data_o  (data1),
      .yumi_i  (yumi)
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
      ,
      .count_o (count1)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; v_in = 1'b1; data_in = 3'b101; yumi = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         tests_run++;
         if (ready0 !== 1'b0 || v0 !== 1'b0 || ready1 !== 1'b0 || v1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold c=%0d: ready0=%b v0=%b ready1=%b v1=%b, required all 0", c, ready0, v0, ready1, v1);
         end
      end
      reset = 1'b0; v_in = 1'b0;
      #1;
      tests_run++;
      if (ready0 !== 1'b1 || v0 !== 1'b0 || data0 !== 3'b000 || ready1 !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release: ready0=%b v0=%b data0=%b ready1=%b, required 1 0 000 1", ready0, v0, data0, ready1);
      end
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
      tests_run++;
      if (count0 !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_count: count0=%0d, required 0", count0);
      end
`endif
      $display("[TB] reset done");
   endtask

   task automatic test_fill();
      v_in = 1'b1; data_in = 3'b011; yumi = 1'b0;
      tick();
      tests_run++;
      if (v0 !== 1'b1 || data0 !== 3'b011 || ready0 !== 1'b1) begin
         tests_failed++;
         $display("FAIL fill_one: v0=%b data0=%b ready0=%b, required 1 011 1", v0, data0, ready0);
      end
      data_in = 3'b110;
      tick();
      tests_run++;
      if (v0 !== 1'b1 || data0 !== 3'b011 || ready0 !== 1'b0 || ready1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill_full: v0=%b data0=%b ready0=%b ready1=%b, required 1 011 0 0", v0, data0, ready0, ready1);
      end
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
      tests_run++;
      if (count0 !== 2'd2) begin
         tests_failed++;
         $display("FAIL fill_count: count0=%0d, required 2", count0);
      end
`endif
      data_in = 3'b111;
      tick();
      tests_run++;
      if (data0 !== 3'b011 || ready0 !== 1'b0 || v0 !== 1'b1) begin
         tests_failed++;
         $display("FAIL fill_ignore: data0=%b ready0=%b v0=%b, required 011 0 1", data0, ready0, v0);
      end
      v_in = 1'b0;
      $display("[TB] fill: enq 011, enq 110, third ignored");
   endtask

   task automatic test_drain();
      yumi = 1'b1;
      #1;
      tests_run++;
      if (data0 !== 3'b011) begin
         tests_failed++;
         $display("FAIL drain_first: data0=%b, required 011", data0);
      end
      tick();
      tests_run++;
      if (v0 !== 1'b1 || data0 !== 3'b110) begin
         tests_failed++;
         $display("FAIL drain_second: v0=%b data0=%b, required 1 110", v0, data0);
      end
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
      tests_run++;
      if (count0 !== 2'd1) begin
         tests_failed++;
         $display("FAIL drain_count1: count0=%0d, required 1", count0);
      end
`endif
      tick();
      yumi = 1'b0;
      #1;
      tests_run++;
      if (v0 !== 1'b0 || ready0 !== 1'b1 || v1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_empty: v0=%b ready0=%b v1=%b, required 0 1 0", v0, ready0, v1);
      end
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
      tests_run++;
      if (count0 !== 2'd0) begin
         tests_failed++;
         $display("FAIL drain_count0: count0=%0d, required 0", count0);
      end
`endif
      $display("[TB] drain: deq 011, deq 110");
   endtask

   task automatic test_streaming();
      logic [2:0] exp_data;
      exp_data = 3'd0;
      for (int i = 0; i < 10; i++) begin
         v_in    = (i < 8);
         data_in = 3'(i);
         yumi    = v0;
         #1;
         tests_run++;
         if (i >= 1 && i <= 8) begin
            if (v0 !== 1'b1 || data0 !== exp_data || ready0 !== 1'b1) begin
               tests_failed++;
               $display("FAIL stream i=%0d: v0=%b data0=%0d ready0=%b, required 1 %0d 1", i, v0, data0, ready0, exp_data);
            end else begin
               $display("[TB] stream deq %0d", data0);
            end
            exp_data = exp_data + 3'd1;
         end else begin
            if (v0 !== 1'b0) begin
               tests_failed++;
               $display("FAIL stream_idle i=%0d: v0=%b, required 0", i, v0);
            end
         end
         tick();
      end
      v_in = 1'b0; yumi = 1'b0;
   endtask

   task automatic test_full_enq_deq();
      v_in = 1'b1; yumi = 1'b0; data_in = 3'b010;
      tick();
      data_in = 3'b100;
      tick();
      data_in = 3'b111; yumi = 1'b1;
      #1;
      tests_run++;
      if (ready0 !== 1'b0 || ready1 !== 1'b1 || data0 !== 3'b010 || data1 !== 3'b010) begin
         tests_failed++;
         $display("FAIL full_ready: ready0=%b ready1=%b data0=%b data1=%b, required 0 1 010 010", ready0, ready1, data0, data1);
      end
      tick();
      v_in = 1'b0; yumi = 1'b0;
      #1;
      tests_run++;
      if (v0 !== 1'b1 || data0 !== 3'b100 || ready0 !== 1'b1) begin
         tests_failed++;
         $display("FAIL full_p0_after: v0=%b data0=%b ready0=%b, required 1 100 1", v0, data0, ready0);
      end
      tests_run++;
      if (v1 !== 1'b1 || data1 !== 3'b100 || ready1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_p1_after: v1=%b data1=%b ready1=%b, required 1 100 0", v1, data1, ready1);
      end
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
      tests_run++;
      if (count0 !== 2'd1 || count1 !== 2'd2) begin
         tests_failed++;
         $display("FAIL full_count: count0=%0d count1=%0d, required 1 2", count0, count1);
      end
`endif
      yumi = 1'b1;
      tick();
      tests_run++;
      if (v0 !== 1'b0 || v1 !== 1'b1 || data1 !== 3'b111) begin
         tests_failed++;
         $display("FAIL full_p1_order: v0=%b v1=%b data1=%b, required 0 1 111", v0, v1, data1);
      end
      // yumi stays high here while dut0 is empty: dut0 must not change state
      tick();
      yumi = 1'b0;
      #1;
      tests_run++;
      if (v0 !== 1'b0 || ready0 !== 1'b1 || v1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL empty_yumi: v0=%b ready0=%b v1=%b, required 0 1 0", v0, ready0, v1);
      end
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
      tests_run++;
      if (count0 !== 2'd0) begin
         tests_failed++;
         $display("FAIL empty_yumi_count: count0=%0d, required 0", count0);
      end
`endif
      v_in = 1'b1; data_in = 3'b101;
      tick();
      v_in = 1'b0;
      #1;
      tests_run++;
      if (v0 !== 1'b1 || data0 !== 3'b101 || v1 !== 1'b1 || data1 !== 3'b101) begin
         tests_failed++;
         $display("FAIL empty_yumi_recover: v0=%b data0=%b v1=%b data1=%b, required 1 101 1 101", v0, data0, v1, data1);
      end
      yumi = 1'b1;
      tick();
      yumi = 1'b0;
      $display("[TB] full enq&deq done");
   endtask

   task automatic test_midop_reset();
      v_in = 1'b1; yumi = 1'b0; data_in = 3'b011;
      tick();
      data_in = 3'b110;
      tick();
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
      tests_run++;
      if (count0 !== 2'd2) begin
         tests_failed++;
         $display("FAIL midop_count2: count0=%0d, required 2", count0);
      end
`endif
      reset = 1'b1;
      #1;
      tests_run++;
      if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL midop_ready: ready0=%b ready1=%b, required 0 0", ready0, ready1);
      end
      tick();
      tests_run++;
      if (v0 !== 1'b0 || v1 !== 1'b0 || ready0 !== 1'b0) begin
         tests_failed++;
         $display("FAIL midop_reset: v0=%b v1=%b ready0=%b, required 0 0 0", v0, v1, ready0);
      end
`ifdef BSG_TWO_FIFO_RV_COUNT_EN
      tests_run++;
      if (count0 !== 2'd0 || count1 !== 2'd0) begin
         tests_failed++;
         $display("FAIL midop_count0: count0=%0d count1=%0d, required 0 0", count0, count1);
      end
`endif
      reset = 1'b0; v_in = 1'b0;
      #1;
      tests_run++;
      if (v0 !== 1'b0 || data0 !== 3'b000 || ready0 !== 1'b1) begin
         tests_failed++;
         $display("FAIL midop_release: v0=%b data0=%b ready0=%b, required 0 000 1", v0, data0, ready0);
      end
      $display("[TB] mid-op reset done");
   endtask

   initial begin
      reset = 1'b1; v_in = 1'b0; data_in = 3'b000; yumi = 1'b0;
      test_reset();
      test_fill();
      test_drain();
      test_streaming();
      test_full_enq_deq();
      test_midop_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
